// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_ctrl_pkg
//  Description : Shared types and defaults for the UART TX scheduler slice.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_ctrl_pkg;

  // Scheduler sequence: grant, then one state per TX strobe, then frame wait
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  localparam int NUM_REQ_DEFAULT      = 4;
  localparam int DATA_W_DEFAULT       = 8;
  localparam int FRAME_CYCLES_DEFAULT = 10;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the first set request
//                at or after the pointer, wrapping past NUM_REQ-1 to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  // One extra bit so pointer+offset never overflows before the wrap
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan requesters in rotated order; the first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_sum = {1'b0, pointer} + (PTR_W+1)'(off);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!any_req && req[w_idx]) begin
        any_req      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin sharing of one UART TX block among NUM_REQ byte
//                requesters. Latches the winning byte, issues the load /
//                byte-ready / start strobes and holds off further grants
//                until the frame has shifted out.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [DATA_W-1:0]           data_bus,
  output logic                        load_XMT_register,
  output logic                        Byte_ready,
  output logic                        T_byte
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;
  logic               ready_q, ready_d;
  logic               tbyte_q, tbyte_d;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_arbiter (
    .req       (req),
    .pointer   (ptr_q),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx),
    .any_req   (w_any_req)
  );

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      ready_q    <= 1'b0;
      tbyte_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      ready_q    <= ready_d;
      tbyte_q    <= tbyte_d;
    end
  end

  // Next-state logic; strobes are registered so each lands one clk after its state
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    busy_d     = busy_q;
    ack_d      = '0;
    load_d     = 1'b0;
    ready_d    = 1'b0;
    tbyte_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          grant_id_d = w_arb_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_idx == ID_W'(i)) begin
              data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
          ack_d   = w_arb_grant;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_d  = 1'b1;
        state_d = ST_READY;
      end
      ST_READY: begin
        ready_d = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        tbyte_d = 1'b1;
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack               = ack_q;
  assign busy              = busy_q;
  assign grant_id          = grant_id_q;
  assign data_bus          = data_q;
  assign load_XMT_register = load_q;
  assign Byte_ready        = ready_q;
  assign T_byte            = tbyte_q;

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Directed self-checking bench for uart_tx_scheduler
//                (NUM_REQ=4, DATA_W=8, FRAME_CYCLES=10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  data_bus;
  logic        load_XMT_register;
  logic        Byte_ready;
  logic        T_byte;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_scheduler #(
    .NUM_REQ      (4),
    .DATA_W       (8),
    .FRAME_CYCLES (10)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .req_data          (req_data),
    .ack               (ack),
    .busy              (busy),
    .grant_id          (grant_id),
    .data_bus          (data_bus),
    .load_XMT_register (load_XMT_register),
    .Byte_ready        (Byte_ready),
    .T_byte            (T_byte)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one clock; land 1 ns after the edge for sampling and driving
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait for the next ack pulse
  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Bounded wait for busy to drop
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ack, busy, grant_id, data_bus, load_XMT_register, Byte_ready, T_byte} !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs: got ack=%b busy=%b gid=%0d data=%h strobes=%b%b%b, expected all 0",
                 ack, busy, grant_id, data_bus, load_XMT_register, Byte_ready, T_byte);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0001 || busy !== 1'b1 || grant_id !== 2'd0 || data_bus !== 8'h11) begin
      errors++;
      $display("FAIL reset_release_grant: got ack=%b busy=%b gid=%0d data=%h, expected ack=0001 busy=1 gid=0 data=11",
               ack, busy, grant_id, data_bus);
    end
    req = 4'b0000;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_idle_timeout: got busy=%b, expected 0 within 40 clks", busy);
    end
  endtask

  task automatic test_single();
    int n;
    req_data = 32'h00F00000;
    req      = 4'b0100;
    tick();
    checks++;
    if (ack !== 4'b0100 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_ack: got ack=%b gid=%0d, expected ack=0100 gid=2", ack, grant_id);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({load_XMT_register, Byte_ready, T_byte} !== 3'b100 || data_bus !== 8'hF0) begin
      errors++;
      $display("FAIL single_load: got strobes=%b%b%b data=%h, expected 100 data=f0",
               load_XMT_register, Byte_ready, T_byte, data_bus);
    end
    tick();
    checks++;
    if ({load_XMT_register, Byte_ready, T_byte} !== 3'b010) begin
      errors++;
      $display("FAIL single_ready: got strobes=%b%b%b, expected 010",
               load_XMT_register, Byte_ready, T_byte);
    end
    tick();
    checks++;
    if ({load_XMT_register, Byte_ready, T_byte} !== 3'b001 || data_bus !== 8'hF0) begin
      errors++;
      $display("FAIL single_tbyte: got strobes=%b%b%b data=%h, expected 001 data=f0",
               load_XMT_register, Byte_ready, T_byte, data_bus);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (!busy) break;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL single_frame_len: busy dropped %0d clks after T_byte, expected 10", n);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    req_data = 32'hB30000B0;
    req      = 4'b1001;
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b1000 || grant_id !== 2'd3 || data_bus !== 8'hB3) begin
      errors++;
      $display("FAIL wrap_first: got ok=%b ack=%b gid=%0d data=%h, expected ack=1000 gid=3 data=b3",
               ok, ack, grant_id, data_bus);
    end
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0001 || grant_id !== 2'd0 || data_bus !== 8'hB0) begin
      errors++;
      $display("FAIL wrap_second: got ok=%b ack=%b gid=%0d data=%h, expected ack=0001 gid=0 data=b0",
               ok, ack, grant_id, data_bus);
    end
    req = 4'b0000;
    wait_idle(ok);
    req = 4'b1001;
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b1000 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_ptr1: got ok=%b ack=%b gid=%0d, expected ack=1000 gid=3", ok, ack, grant_id);
    end
    req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    int last;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_byte [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    last     = 0;
    req_data = 32'hA3A2A1A0;
    req      = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(ok);
      checks++;
      if (!ok || ack !== 4'(1 << exp_order[g]) || grant_id !== 2'(exp_order[g])
          || data_bus !== exp_byte[g]) begin
        errors++;
        $display("FAIL rr_grant%0d: got ok=%b ack=%b gid=%0d data=%h, expected gid=%0d data=%h",
                 g, ok, ack, grant_id, data_bus, exp_order[g], exp_byte[g]);
      end
      repeat (3) tick();
      checks++;
      if (T_byte !== 1'b1) begin
        errors++;
        $display("FAIL rr_tbyte%0d: got T_byte=%b 3 clks after ack, expected 1", g, T_byte);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last !== 14) begin
          errors++;
          $display("FAIL rr_spacing%0d: got %0d clks between T_byte pulses, expected 14", g, cyc - last);
        end
      end
      last = cyc;
    end
    req = 4'b0000;
    wait_idle(ok);
  endtask

  task automatic test_data_stability();
    bit ok;
    req_data = 32'h0000D300;
    req      = 4'b0010;
    wait_ack(ok);
    checks++;
    if (!ok || ack !== 4'b0010 || data_bus !== 8'hD3) begin
      errors++;
      $display("FAIL stab_grant: got ok=%b ack=%b data=%h, expected ack=0010 data=d3", ok, ack, data_bus);
    end
    req = 4'b0000;
    repeat (6) tick();
    req_data = 32'h00000000;
    repeat (3) tick();
    checks++;
    if (data_bus !== 8'hD3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stab_midframe: got data=%h busy=%b, expected data=d3 busy=1", data_bus, busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || data_bus !== 8'hD3) begin
      errors++;
      $display("FAIL stab_after_frame: got ok=%b data=%h, expected data=d3", ok, data_bus);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    req_data = 32'h005A0000;
    req      = 4'b0100;
    wait_ack(ok);
    req = 4'b0000;
    repeat (3) tick();
    checks++;
    if (T_byte !== 1'b1) begin
      errors++;
      $display("FAIL rmid_tbyte: got T_byte=%b, expected 1", T_byte);
    end
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, load_XMT_register, Byte_ready, T_byte} !== 4'b0000 || data_bus !== 8'h00
        || grant_id !== 2'd0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_async_clear: got busy=%b strobes=%b%b%b data=%h gid=%0d ack=%b, expected all 0",
               busy, load_XMT_register, Byte_ready, T_byte, data_bus, grant_id, ack);
    end
    req_data = 32'h00007700;
    req      = 4'b0010;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0010 || grant_id !== 2'd1 || data_bus !== 8'h77 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_regrant: got ack=%b gid=%0d data=%h busy=%b, expected ack=0010 gid=1 data=77 busy=1",
               ack, grant_id, data_bus, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (load_XMT_register !== 1'b1) begin
      errors++;
      $display("FAIL rmid_load: got load=%b, expected 1", load_XMT_register);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rmid_idle_timeout: got busy=%b, expected 0 within 40 clks", busy);
    end
  endtask

  task automatic test_no_serve();
    req_data = 32'h000000EE;
    req      = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_serve%0d: got ack=%b busy=%b, expected ack=0000 busy=0", i, ack, busy);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_data_stability();
    test_reset_mid_frame();
    test_no_serve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
